fifo_pkt_infill: RTL and testbench
==================================

Name: fifo_pkt_infill

Overview:
Single-clock, show-ahead streaming packet FIFO with a read-only CSR fill-level port.
- Buffers beats of a packetised valid/ready stream: data, startofpacket, endofpacket, empty.
- Exposes current occupancy so the wrapper above can derive almost_full back-pressure.
- Sits between packet-processing stages; M20K inference is the default storage target.

Parameters:
SYMBOLS_PER_BEAT, 64, symbols per beat
BITS_PER_SYMBOL, 8, bits per symbol; data width DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL
FIFO_DEPTH, 512, capacity in beats; power of two, >= 4
USE_PACKETS, 1, 1 = store sop/eop/empty; 0 = do not store them, those outputs are driven 0
EMPTY_WIDTH, 6, width of the empty field; must equal log2(SYMBOLS_PER_BEAT)

Ports:
in_clk  in  1  clock for all logic
rst_l  in  1  asynchronous active-low reset
csr_address  in  1  0 = fill level; 1 = capacity
csr_read  in  1  read strobe
csr_write  in  1  write strobe; all writes ignored
csr_writedata  in  32  ignored
csr_readdata  out  32  registered CSR read data
in_data  in  DW  input beat
in_valid  in  1  input valid
in_ready  out  1  FIFO can accept a beat
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  EMPTY_WIDTH  unused symbols in the last beat
out_data  out  DW  head beat
out_valid  out  1  head beat valid
out_ready  in  1  consumer accepts the head beat
out_startofpacket  out  1  head sop
out_endofpacket  out  1  head eop
out_empty  out  EMPTY_WIDTH  head empty

Behaviour:
- Reset (rst_l low, asynchronous):
  - Pointers and count go to 0.
  - out_valid=0, in_ready=1, csr_readdata=0.
  - out_data, out_startofpacket, out_endofpacket and out_empty go to 0.
  - Memory contents are not cleared.
  - Reset asserted mid-packet discards all stored beats; no partial-packet recovery.
- Push: in_valid & in_ready at a rising edge writes {data, sop, eop, empty} at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- Pop: out_valid & out_ready at a rising edge advances the head.
- in_ready = (count < FIFO_DEPTH); combinational from registered count, no dependence on in_valid.
- Show-ahead latency: a beat pushed into an empty FIFO at edge k has out_valid=1 and its fields on out_* after edge k+1 (2-cycle write-to-read, registered RAM read).
- out_* hold stable while out_valid & !out_ready.
- count = beats accepted minus beats popped, including the head beat. Range 0..FIFO_DEPTH, width log2(FIFO_DEPTH)+1.
- Simultaneous push and pop: count unchanged; both succeed.
- Full boundary:
  - At count = FIFO_DEPTH, in_ready=0 and in_valid is ignored.
  - A pop in the same cycle does not enable a push in that cycle; in_ready rises the cycle after.
- Empty boundary: out_valid=0 and out_ready is ignored.
- Packet fields are stored verbatim. No packet-boundary checking, no drop on malformed sop/eop.
- CSR read:
  - csr_readdata is registered and updates every edge at which csr_read=1.
  - Address 0 returns the zero-extended count as of the previous edge (one-cycle stale).
  - Address 1 returns FIFO_DEPTH.
  - When csr_read=0, csr_readdata holds its value.
- No overflow/underflow error outputs; illegal pushes or pops are simply not accepted.

Optional Feature:
Macro FIFO_TRACE_EN.
- Defined:
  - Adds a 32-bit cycle counter (reset 0, +1 per clock).
  - Issues a simulation $display on every accepted push ("PUSH cycle=<n> fill=<count>") and every accepted pop ("POP cycle=<n> fill=<count>").
  - Issues one "PKT PUSH" or "PKT POP" line on the first beat of each contiguous accepted burst.
  - Non-synthesizable, guarded for simulation only.
- Undefined: no counter and no messages; functional behaviour is identical either way.

Test Plan:
1. Reset then idle: rst_l=0 for 3 cycles, release → out_valid=0, in_ready=1, csr read addr 0 returns 0, addr 1 returns 512.
2. Single packet: push 3 beats (data 0xA1/0xA2/0xA3, sop on beat 1, eop+empty=5 on beat 3), out_ready=1 → same 3 beats out in order with sop/eop/empty intact; first beat out_valid 2 cycles after its push; final count 0.
3. Fill to full: out_ready=0, push 512 beats → in_ready=0 after the 512th; the 513th offered beat is not accepted; csr addr 0 reads 512.
4. Full with simultaneous push/pop: at count 512 assert out_ready=1 with in_valid=1 → one pop, no push that cycle, count 511; push accepted the next cycle, count stays 511 under continuous push/pop.
5. Wrap-around and backpressure: stream 1500 beats with out_ready toggled 50% pseudo-randomly → output matches input sequence exactly; out_* stable while stalled.
6. Reset mid-packet: assert rst_l=0 with count 7 during a packet → out_valid=0 immediately (asynchronous); after release, the next packet emerges alone with no stale beats.

Source files
------------

// File: rtl/fifo_pkt_infill.sv
// Show-ahead packet FIFO with registered RAM read and a read-only CSR fill-level port.
// Define FIFO_TRACE_EN to get simulation-only push/pop trace messages.
module fifo_pkt_infill #(
   parameter int unsigned SYMBOLS_PER_BEAT = 64,
   parameter int unsigned BITS_PER_SYMBOL  = 8,
   parameter int unsigned FIFO_DEPTH       = 512,
   parameter int unsigned USE_PACKETS      = 1,
   parameter int unsigned EMPTY_WIDTH      = 6,
   localparam int unsigned DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
   input  logic                   in_clk,
   input  logic                   rst_l,
   input  logic                   csr_address,
   input  logic                   csr_read,
   input  logic                   csr_write,
   input  logic [31:0]            csr_writedata,
   output logic [31:0]            csr_readdata,
   input  logic [DW-1:0]          in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_startofpacket,
   input  logic                   in_endofpacket,
   input  logic [EMPTY_WIDTH-1:0] in_empty,
   output logic [DW-1:0]          out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_startofpacket,
   output logic                   out_endofpacket,
   output logic [EMPTY_WIDTH-1:0] out_empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = (USE_PACKETS != 0) ? EMPTY_WIDTH + 2 : 0;
   localparam int unsigned WW = DW + PW;

   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [WW-1:0] wr_word;
   logic [WW-1:0] head_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] ram_cnt_q, ram_cnt_d;
   logic          out_valid_q;
   logic [31:0]   csr_readdata_q;
   logic          push, pop, load;

   logic unused_csr;
   assign unused_csr = ^{csr_write, csr_writedata};

   assign in_ready = (count_q < CW'(FIFO_DEPTH));
   assign push     = in_valid & in_ready;
   assign pop      = out_valid_q & out_ready;
   // Refill the head register whenever it is free or being consumed and the RAM holds a beat.
   assign load     = (ram_cnt_q != '0) & (~out_valid_q | out_ready);

   always_comb begin
      count_d   = count_q + CW'(push) - CW'(pop);
      ram_cnt_d = ram_cnt_q + CW'(push) - CW'(load);
   end

   always_ff @(posedge in_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_word;
      end
   end

   always_ff @(posedge in_clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ram_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         head_q      <= '0;
      end else begin
         count_q   <= count_d;
         ram_cnt_q <= ram_cnt_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (load) begin
            rd_ptr_q    <= rd_ptr_q + AW'(1);
            head_q      <= mem[rd_ptr_q];
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge in_clk or negedge rst_l) begin
      if (!rst_l) begin
         csr_readdata_q <= '0;
      end else if (csr_read) begin
         csr_readdata_q <= csr_address ? 32'(FIFO_DEPTH) : 32'(count_q);
      end
   end

   assign csr_readdata = csr_readdata_q;
   assign out_valid    = out_valid_q;
   assign out_data     = head_q[DW-1:0];

   if (USE_PACKETS != 0) begin : g_pkt
      assign wr_word           = {in_startofpacket, in_endofpacket, in_empty, in_data};
      assign out_startofpacket = head_q[DW+EMPTY_WIDTH+1];
      assign out_endofpacket   = head_q[DW+EMPTY_WIDTH];
      assign out_empty         = head_q[DW +: EMPTY_WIDTH];
   end else begin : g_nopkt
      logic unused_pkt;
      assign unused_pkt        = ^{in_startofpacket, in_endofpacket, in_empty};
      assign wr_word           = in_data;
      assign out_startofpacket = 1'b0;
      assign out_endofpacket   = 1'b0;
      assign out_empty         = '0;
   end

`ifdef FIFO_TRACE_EN
   logic [31:0] trace_cycle_q;
   logic        trace_push_q, trace_pop_q;

   always_ff @(posedge in_clk or negedge rst_l) begin
      if (!rst_l) begin
         trace_cycle_q <= '0;
         trace_push_q  <= 1'b0;
         trace_pop_q   <= 1'b0;
      end else begin
         trace_cycle_q <= trace_cycle_q + 32'd1;
         trace_push_q  <= push;
         trace_pop_q   <= pop;
      end
   end

   always @(posedge in_clk) begin
      if (rst_l) begin
         if (push && !trace_push_q) $display("PKT PUSH cycle=%0d", trace_cycle_q);
         if (push) $display("PUSH cycle=%0d fill=%0d", trace_cycle_q, count_d);
         if (pop && !trace_pop_q) $display("PKT POP cycle=%0d", trace_cycle_q);
         if (pop) $display("POP cycle=%0d fill=%0d", trace_cycle_q, count_d);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_pkt_infill.sv
// Directed bench for fifo_pkt_infill: reset, single packet, full boundary, wrap with
// random backpressure and mid-packet reset.
module tb_fifo_pkt_infill;

   localparam int unsigned DW    = 512;
   localparam int unsigned EW    = 6;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned BW    = DW + EW + 2;

   logic          in_clk = 1'b0;
   logic          rst_l;
   logic          csr_address, csr_read, csr_write;
   logic [31:0]   csr_writedata, csr_readdata;
   logic [DW-1:0] in_data, out_data;
   logic          in_valid, in_ready, in_startofpacket, in_endofpacket;
   logic [EW-1:0] in_empty, out_empty;
   logic          out_valid, out_ready, out_startofpacket, out_endofpacket;
   logic [BW-1:0] out_beat;

   int nvec = 0;
   int nbad = 0;

   assign out_beat = {out_startofpacket, out_endofpacket, out_empty, out_data};

   fifo_pkt_infill dut (
      .in_clk            (in_clk),
      .rst_l             (rst_l),
      .csr_address       (csr_address),
      .csr_read          (csr_read),
      .csr_write         (csr_write),
      .csr_writedata     (csr_writedata),
      .csr_readdata      (csr_readdata),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_empty         (out_empty)
   );

   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic drive_beat(input logic [BW-1:0] b);
      in_valid         = 1'b1;
      in_startofpacket = b[BW-1];
      in_endofpacket   = b[BW-2];
      in_empty         = b[DW +: EW];
      in_data          = b[DW-1:0];
   endtask

   function automatic logic [BW-1:0] mk_beat(input logic sop, input logic eop,
                                             input logic [EW-1:0] emp, input logic [31:0] d);
      return {sop, eop, emp, DW'(d)};
   endfunction

   // Sequence-numbered beat used by the streaming test; all fields derive from s.
   function automatic logic [BW-1:0] seq_beat(input int s);
      logic [31:0] sv;
      sv = s;
      return {sv[0], sv[1], sv[7:2], {16{sv}}};
   endfunction

   task automatic test_reset();
      rst_l = 1'b0;
      repeat (3) tick();
      nvec++;
      if (out_valid !== 1'b0) begin
         nbad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      nvec++;
      if (in_ready !== 1'b1) begin
         nbad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      nvec++;
      if (out_beat !== '0 || csr_readdata !== 32'd0) begin
         nbad++; $display("FAIL reset_outputs: beat %h csr %h want 0", out_beat, csr_readdata);
      end
      rst_l = 1'b1;
      tick();
      csr_read = 1'b1; csr_address = 1'b0;
      csr_write = 1'b1; csr_writedata = 32'hDEAD_BEEF;
      tick();
      nvec++;
      if (csr_readdata !== 32'd0) begin
         nbad++; $display("FAIL csr_fill_idle: got %0d want 0", csr_readdata);
      end
      csr_address = 1'b1;
      tick();
      nvec++;
      if (csr_readdata !== 32'd512) begin
         nbad++; $display("FAIL csr_capacity: got %0d want 512", csr_readdata);
      end
      csr_read = 1'b0; csr_write = 1'b0; csr_address = 1'b0;
      tick();
      nvec++;
      if (csr_readdata !== 32'd512) begin
         nbad++; $display("FAIL csr_hold: got %0d want 512", csr_readdata);
      end
   endtask

   task automatic test_single_packet();
      logic [BW-1:0] b1, b2, b3;
      b1 = mk_beat(1'b1, 1'b0, 6'd0, 32'hA1);
      b2 = mk_beat(1'b0, 1'b0, 6'd0, 32'hA2);
      b3 = mk_beat(1'b0, 1'b1, 6'd5, 32'hA3);
      out_ready = 1'b1;
      drive_beat(b1);
      tick();
      nvec++;
      if (out_valid !== 1'b0) begin
         nbad++; $display("FAIL single_latency: out_valid %b want 0 one edge after push", out_valid);
      end
      drive_beat(b2);
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_beat !== b1) begin
         nbad++; $display("FAIL single_beat1: valid %b beat %h want 1 %h", out_valid, out_beat, b1);
      end
      drive_beat(b3);
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_beat !== b2) begin
         nbad++; $display("FAIL single_beat2: valid %b beat %h want 1 %h", out_valid, out_beat, b2);
      end
      in_valid = 1'b0;
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_beat !== b3) begin
         nbad++; $display("FAIL single_beat3: valid %b beat %h want 1 %h", out_valid, out_beat, b3);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b0) begin
         nbad++; $display("FAIL single_drained: out_valid %b want 0", out_valid);
      end
      csr_read = 1'b1; csr_address = 1'b0;
      tick();
      csr_read = 1'b0;
      nvec++;
      if (csr_readdata !== 32'd0) begin
         nbad++; $display("FAIL single_count: got %0d want 0", csr_readdata);
      end
   endtask

   task automatic test_fill_full();
      out_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive_beat(mk_beat(1'b0, 1'b0, 6'd0, 32'(i)));
         if (i == int'(DEPTH) - 1) begin
            nvec++;
            if (in_ready !== 1'b1) begin
               nbad++; $display("FAIL fill_last_ready: got %b want 1", in_ready);
            end
         end
         tick();
      end
      nvec++;
      if (in_ready !== 1'b0) begin
         nbad++; $display("FAIL fill_full_ready: got %b want 0", in_ready);
      end
      drive_beat(mk_beat(1'b0, 1'b0, 6'd0, 32'd512));
      tick();
      nvec++;
      if (in_ready !== 1'b0 || out_data !== DW'(0)) begin
         nbad++; $display("FAIL fill_reject: ready %b head %0h want 0 0", in_ready, out_data);
      end
      csr_read = 1'b1; csr_address = 1'b0;
      tick();
      csr_read = 1'b0;
      nvec++;
      if (csr_readdata !== 32'd512) begin
         nbad++; $display("FAIL fill_count: got %0d want 512", csr_readdata);
      end
   endtask

   task automatic test_full_push_pop();
      int exp;
      out_ready = 1'b1;
      drive_beat(mk_beat(1'b0, 1'b0, 6'd0, 32'd512));
      tick();
      nvec++;
      if (in_ready !== 1'b1 || out_data !== DW'(1)) begin
         nbad++; $display("FAIL full_pop_only: ready %b head %0h want 1 1", in_ready, out_data);
      end
      csr_read = 1'b1; csr_address = 1'b0;
      for (int t = 2; t <= 5; t++) begin
         drive_beat(mk_beat(1'b0, 1'b0, 6'd0, 32'(510 + t)));
         tick();
         nvec++;
         if (out_data !== DW'(t) || csr_readdata !== 32'd511) begin
            nbad++;
            $display("FAIL full_stream: head %0h count %0d want %0h 511", out_data, csr_readdata, t);
         end
      end
      in_valid = 1'b0; csr_read = 1'b0;
      exp = 5;
      for (int c = 0; c < 700 && exp < 516; c++) begin
         if (out_valid) begin
            nvec++;
            if (out_data !== DW'(exp)) begin
               nbad++; $display("FAIL full_drain: got %0h want %0h", out_data, exp);
            end
            exp++;
         end
         tick();
      end
      nvec++;
      if (exp != 516 || out_valid !== 1'b0) begin
         nbad++; $display("FAIL full_drain_end: reached %0d valid %b want 516 0", exp, out_valid);
      end
   endtask

   task automatic test_wrap_backpressure();
      localparam int N = 1500;
      int sent = 0;
      int recv = 0;
      logic stall = 1'b0;
      logic rdy, acc;
      logic [BW-1:0] prev = '0;
      for (int c = 0; c < 20000 && recv < N; c++) begin
         if (stall) begin
            nvec++;
            if (out_valid !== 1'b1 || out_beat !== prev) begin
               nbad++; $display("FAIL wrap_stall_hold: valid %b beat %h want 1 %h",
                                out_valid, out_beat, prev);
            end
         end
         rdy = 1'($urandom_range(0, 1));
         out_ready = rdy;
         if (out_valid) begin
            nvec++;
            if (out_beat !== seq_beat(recv)) begin
               nbad++; $display("FAIL wrap_data: beat %h want %h", out_beat, seq_beat(recv));
            end
            if (rdy) recv++;
         end
         stall = out_valid && !rdy;
         prev  = out_beat;
         if (sent < N) drive_beat(seq_beat(sent));
         else in_valid = 1'b0;
         acc = (sent < N) && in_ready;
         tick();
         if (acc) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      nvec++;
      if (recv != N) begin
         nbad++; $display("FAIL wrap_count: received %0d want %0d", recv, N);
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [BW-1:0] exp_b [3];
      int j;
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive_beat(mk_beat(i == 0, 1'b0, 6'd0, 32'(256 + i)));
         tick();
      end
      in_valid = 1'b0;
      csr_read = 1'b1; csr_address = 1'b0;
      tick();
      csr_read = 1'b0;
      nvec++;
      if (csr_readdata !== 32'd7 || out_valid !== 1'b1) begin
         nbad++; $display("FAIL midrst_pre: count %0d valid %b want 7 1", csr_readdata, out_valid);
      end
      #2 rst_l = 1'b0;
      #1;
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_beat !== '0 || csr_readdata !== 32'd0) begin
         nbad++; $display("FAIL midrst_async: valid %b ready %b beat %h csr %0d want 0 1 0 0",
                          out_valid, in_ready, out_beat, csr_readdata);
      end
      tick(); tick();
      rst_l = 1'b1;
      tick();
      exp_b[0] = mk_beat(1'b1, 1'b0, 6'd0, 32'h300);
      exp_b[1] = mk_beat(1'b0, 1'b0, 6'd0, 32'h301);
      exp_b[2] = mk_beat(1'b0, 1'b1, 6'd3, 32'h302);
      out_ready = 1'b1;
      j = 0;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) drive_beat(exp_b[c]);
         else in_valid = 1'b0;
         tick();
         if (out_valid) begin
            nvec++;
            if (j >= 3) begin
               nbad++; $display("FAIL midrst_extra: beat %h want none", out_beat);
            end else if (out_beat !== exp_b[j]) begin
               nbad++; $display("FAIL midrst_beat: got %h want %h", out_beat, exp_b[j]);
            end
            j++;
         end
      end
      nvec++;
      if (j != 3) begin
         nbad++; $display("FAIL midrst_count: got %0d beats want 3", j);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_l = 1'b0;
      csr_address = 1'b0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
      in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
      in_empty = '0; out_ready = 1'b0;
      test_reset();
      test_single_packet();
      test_fill_full();
      test_full_push_pop();
      test_wrap_backpressure();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
